// File: rtl/spigot_digit_receiver.sv
// spigot_digit_receiver
//   Far-end consumer of the spigot-e digit bus. Synchronises the 16-bit pin
//   bus (four BCD digits) and its enable pin, waits until a new group has been
//   stable for STABLE_CYCLES samples, validates it as BCD and pushes the four
//   digits atomically into a FIFO. The FIFO drains as ASCII characters over a
//   valid/ready stream.
//
// Ports
//   clk             single clock
//   reset           asynchronous, active-high reset
//   io_ena          transmitter enable pin; bus ignored while low
//   io_bus          [15:12]=digit0 .. [3:0]=digit3
//   io_digit_ready  downstream ready
//   io_digit_valid  FIFO head valid
//   io_digit_ascii  8'h30 + FIFO head digit (8'h30 when empty)
//   io_fifo_level   digits currently held
//   io_overflow     sticky: group dropped for lack of 4 free entries
//   io_bcd_error    sticky: group dropped because a nibble was > 9
module spigot_digit_receiver #(
  parameter int STABLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          io_ena,
  input  logic [15:0]                   io_bus,
  input  logic                          io_digit_ready,
  output logic                          io_digit_valid,
  output logic [7:0]                    io_digit_ascii,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_level,
  output logic                          io_overflow,
  output logic                          io_bcd_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM    = CW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] PUSH_LIMIT = LW'(FIFO_DEPTH - 4);

  function automatic logic has_bad_nibble(input logic [15:0] g);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (g[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Synchronisers and previous-sample register
  logic        ena_m, ena_s;
  logic [15:0] bus_m, bus_s, bus_prev;

  // Stability filter and accept stage
  logic [CW-1:0] cnt;
  logic          have_group;
  logic [15:0]   last_group;
  logic          accept_q;
  logic [15:0]   group_q;

  // FIFO
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          overflow, bcd_error;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, just like real flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ena_m    <= 1'b0;
      ena_s    <= 1'b0;
      bus_m    <= '0;
      bus_s    <= '0;
      bus_prev <= '0;
    end else begin
      ena_m    <= io_ena;
      ena_s    <= ena_m;
      bus_m    <= io_bus;
      bus_s    <= bus_m;
      bus_prev <= bus_s;
    end
  end

  logic stable, accept;
  assign stable = ena_s && (bus_s == bus_prev);
  // Accept fires on the single cycle the counter steps up to its maximum,
  // and only for a group different from the one last accepted.
  assign accept = stable && (cnt == CNT_ARM) &&
                  (!have_group || (bus_s != last_group));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      have_group <= 1'b0;
      last_group <= '0;
      accept_q   <= 1'b0;
      group_q    <= '0;
    end else begin
      if (!stable)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      accept_q <= accept;
      // last_group is updated even if the group is later dropped, so a held
      // bad or overflowing group is not retried every time it re-stabilises.
      if (accept) begin
        group_q    <= bus_s;
        last_group <= bus_s;
        have_group <= 1'b1;
      end
    end
  end

  // Push stage: BCD validity is judged before capacity, and capacity uses the
  // level before any same-cycle pop.
  logic bad_bcd, has_room, push, drop_full, pop;
  assign bad_bcd   = accept_q && has_bad_nibble(group_q);
  assign has_room  = (level <= PUSH_LIMIT);
  assign push      = accept_q && !bad_bcd && has_room;
  assign drop_full = accept_q && !bad_bcd && !has_room;
  assign pop       = io_digit_valid && io_digit_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      bcd_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(4);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(4);
        2'b01:   level <= level - LW'(1);
        2'b11:   level <= level + LW'(3);
        default: level <= level;
      endcase
      if (bad_bcd)   bcd_error <= 1'b1;
      if (drop_full) overflow  <= 1'b1;
    end
  end

  // NOTE: the digit storage has no reset; the pointers and level define which
  // entries are live, and the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        mem[wr_ptr + AW'(i)] <= group_q[15 - 4*i -: 4];
      end
    end
  end

  assign io_digit_valid = (level != '0);
  assign io_digit_ascii = io_digit_valid ? {4'h3, mem[rd_ptr]} : 8'h30;
  assign io_fifo_level  = level;
  assign io_overflow    = overflow;
  assign io_bcd_error   = bcd_error;

endmodule

// File: tb/tb_spigot_digit_receiver.sv
// Testbench for spigot_digit_receiver: directed scenarios followed by random
// bus traffic, checked against a behavioural model. Expected ASCII digits go
// into a scoreboard queue; a monitor compares them at every handshake.
module tb_spigot_digit_receiver;

  localparam int S     = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_ena;
  logic [15:0] io_bus;
  logic        io_digit_ready;
  logic        io_digit_valid;
  logic [7:0]  io_digit_ascii;
  logic [3:0]  io_fifo_level;
  logic        io_overflow;
  logic        io_bcd_error;

  spigot_digit_receiver #(.STABLE_CYCLES(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_ena         (io_ena),
    .io_bus         (io_bus),
    .io_digit_ready (io_digit_ready),
    .io_digit_valid (io_digit_valid),
    .io_digit_ascii (io_digit_ascii),
    .io_fifo_level  (io_fifo_level),
    .io_overflow    (io_overflow),
    .io_bcd_error   (io_bcd_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  exp_q[$];      // scoreboard of expected ASCII digits
  logic [15:0] seen_b[3];     // pin values driven 1, 2, 3 edges ago
  logic        seen_e[3];
  int          run;           // length of current run of identical enabled samples
  bit          have;
  logic [15:0] last;
  bit          pend;
  logic [15:0] pend_grp;
  int          mlevel;
  bit          m_ovf, m_bcd;

  function automatic bit has_bad(input logic [15:0] g);
    for (int i = 0; i < 4; i++) if (g[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      seen_b[i] = '0;
      seen_e[i] = 1'b0;
    end
    run = 0; have = 0; last = '0; pend = 0; pend_grp = '0;
    mlevel = 0; m_ovf = 0; m_bcd = 0;
    exp_q.delete();
  endtask

  // One clock edge of the receiver, given the pins seen just before it.
  task automatic model_edge(input logic r, input logic e, input logic [15:0] b);
    logic [15:0] sb, sbp;
    logic        se;
    bit          do_push, do_pop;
    logic [7:0]  ch;
    sb = seen_b[1]; sbp = seen_b[2]; se = seen_e[1];
    do_push = 0;
    if (pend) begin
      if (has_bad(pend_grp))        m_bcd = 1;
      else if (DEPTH - mlevel >= 4) do_push = 1;
      else                          m_ovf = 1;
    end
    do_pop = (mlevel != 0) && r;
    if (do_push) begin
      for (int i = 3; i >= 0; i--) begin
        ch = 8'h30 + {4'h0, pend_grp[4*i +: 4]};
        exp_q.push_back(ch);
      end
    end
    mlevel = mlevel + (do_push ? 4 : 0) - (do_pop ? 1 : 0);
    run = (se && sb == sbp) ? run + 1 : 0;
    pend = (run == S) && (!have || sb != last);
    if (pend) begin
      pend_grp = sb;
      last     = sb;
      have     = 1;
    end
    seen_b[2] = seen_b[1]; seen_b[1] = seen_b[0]; seen_b[0] = b;
    seen_e[2] = seen_e[1]; seen_e[1] = seen_e[0]; seen_e[0] = e;
  endtask

  // Drive pins just after a rising edge, advance one edge, check outputs.
  task automatic step(input logic r, input logic e, input logic [15:0] b);
    io_digit_ready = r;
    io_ena         = e;
    io_bus         = b;
    @(posedge clk);
    model_edge(r, e, b);
    #1;
    check("level",     32'(io_fifo_level), 32'(mlevel));
    check("valid",     32'(io_digit_valid), 32'(mlevel != 0));
    check("overflow",  32'(io_overflow), 32'(m_ovf));
    check("bcd_error", 32'(io_bcd_error), 32'(m_bcd));
    if (mlevel == 0) check("idle_ascii", 32'(io_digit_ascii), 32'h30);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_valid",     32'(io_digit_valid), 32'h0);
    check("rst_ascii",     32'(io_digit_ascii), 32'h30);
    check("rst_level",     32'(io_fifo_level), 32'h0);
    check("rst_overflow",  32'(io_overflow), 32'h0);
    check("rst_bcd_error", 32'(io_bcd_error), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && mlevel != 0; i++) step(1'b1, 1'b0, io_bus);
    check("drained", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: samples mid-cycle, after the drive has settled.
  always @(negedge clk) begin
    if (!reset && io_digit_valid && io_digit_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_digit: got %0h expected none at %0t", io_digit_ascii, $time);
      end else begin
        check("digit", 32'(io_digit_ascii), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [15:0] cur;
    int          hold;
    reset = 1'b1; io_ena = 1'b0; io_bus = '0; io_digit_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: held group is delivered once
    repeat (20) step(1'b1, 1'b1, 16'h2718);

    // 2: toggling bus never settles; then a held value is accepted
    repeat (5) begin
      repeat (2) step(1'b1, 1'b1, 16'h2819);
      repeat (2) step(1'b1, 1'b1, 16'h2718);
    end
    repeat (12) step(1'b1, 1'b1, 16'h2819);

    // 3: bad BCD dropped; good group after it still flows
    repeat (10) step(1'b1, 1'b1, 16'h27A8);
    check("bcd_set", 32'(io_bcd_error), 32'h1);
    repeat (12) step(1'b1, 1'b1, 16'h2845);

    // 4: fill with ready low, third group overflows, then drain
    repeat (8) step(1'b0, 1'b1, 16'h1111);
    repeat (8) step(1'b0, 1'b1, 16'h2222);
    check("full_level", 32'(io_fifo_level), 32'h8);
    repeat (8) step(1'b0, 1'b1, 16'h3333);
    check("ovf_set", 32'(io_overflow), 32'h1);
    drain(20);

    // 5a: level 5 with a pop on the push edge -> dropped, level 4
    do_reset();
    repeat (8) step(1'b0, 1'b1, 16'h1111);
    repeat (8) step(1'b0, 1'b1, 16'h2222);
    for (int j = 0; j < 7; j++) step(j >= 3, 1'b1, 16'h3333);
    check("pre_pop_drop_level", 32'(io_fifo_level), 32'h4);
    check("pre_pop_drop_ovf",   32'(io_overflow), 32'h1);
    drain(20);

    // 5b: level 4 with a pop on the push edge -> pushed, level 7
    do_reset();
    repeat (8) step(1'b0, 1'b1, 16'h1111);
    for (int j = 0; j < 7; j++) step(j == 6, 1'b1, 16'h2222);
    check("push_pop_level", 32'(io_fifo_level), 32'h7);
    drain(20);

    // 6: disabled bus queues nothing; async reset mid-drain
    repeat (10) step(1'b1, 1'b0, 16'h5555);
    check("ena_low_level", 32'(io_fifo_level), 32'h0);
    repeat (8) step(1'b0, 1'b1, 16'h6789);
    step(1'b1, 1'b1, 16'h6789);
    check("mid_drain_level", 32'(io_fifo_level), 32'h3);
    do_reset();

    // Random traffic, including invalid nibbles and enable drop-outs
    cur = 16'h0000;
    hold = 0;
    for (int n = 0; n < 2000; n++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 10);
        if ($urandom_range(0, 4) == 0) cur = 16'($urandom);
        else cur = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      hold--;
      step($urandom_range(0, 9) < 4, $urandom_range(0, 19) != 0, cur);
    end
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
